// File: rtl/mask_stream_pkg.sv
// Shared types and constants for the mask stream path (transmitter and row gating).
package mask_stream_pkg;

   localparam int ROWADD_W              = 9;
   localparam int MSTREAM_W             = 16;
   localparam int DEF_NUM_ROW           = 320;
   localparam int DEF_WORDS_PER_ROW     = 20;
   localparam int DEF_ROW_GAP           = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      LOAD   = 2'd2,
      GAP    = 2'd3
   } state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mask_stream_tx_if.sv
// Mask stream bundle: upstream word handshake plus the row-side outputs.
// master = the transmitter block, slave = the surrounding source/sink.
interface mask_stream_tx_if;
   import mask_stream_pkg::*;

   logic [MSTREAM_W-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [ROWADD_W-1:0]  rowadd;
   logic [MSTREAM_W-1:0] mstream;
   logic                 mstream_valid;
   logic                 row_load;

   modport master (
      input  in_data, in_valid,
      output in_ready, rowadd, mstream, mstream_valid, row_load
   );

   modport slave (
      output in_data, in_valid,
      input  in_ready, rowadd, mstream, mstream_valid, row_load
   );

endinterface

// File: rtl/mask_row_counter.sv
// Up-counter 0..MAX with synchronous clear, enable and terminal-count flag.
module mask_row_counter
   import mask_stream_pkg::*;
#(
   parameter int W   = ROWADD_W,
   parameter int MAX = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         tc
);

   assign tc = (count == W'(MAX));

   // Clear wins over enable; wraps to zero after MAX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= tc ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/mask_stream_tx.sv
// Row-sequenced mask word transmitter: groups upstream words into rows,
// drives rowadd / mstream / row_load for the row gating and shift chain.
module mask_stream_tx
   import mask_stream_pkg::*;
#(
   parameter int NUM_ROW       = DEF_NUM_ROW,
   parameter int WORDS_PER_ROW = DEF_WORDS_PER_ROW,
   parameter int ROW_GAP       = DEF_ROW_GAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   mask_stream_tx_if.master ms,
   output logic             busy,
   output logic             done,
   output logic             underrun
);

   localparam int WCNT_W   = cnt_w(WORDS_PER_ROW);
   localparam int GAP_W    = cnt_w(ROW_GAP + 1);
   localparam int GAP_INIT = (ROW_GAP > 0) ? ROW_GAP - 1 : 0;

   state_t              state, state_nxt;
   logic [WCNT_W-1:0]   word_cnt;
   logic                word_tc;
   logic [ROWADD_W-1:0] row_cnt;
   logic                row_tc;
   logic [GAP_W-1:0]    gap_cnt;
   logic                accept;
   logic                start_acc;
   logic                word_clr;
   logic                row_clr;
   logic                row_en;

   // A word presented in the abort cycle is dropped: the stream is being flushed.
   assign accept    = ms.in_valid && ms.in_ready && !abort;
   assign start_acc = start && !abort && (state == IDLE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode; abort overrides every transition.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start)                 state_nxt = STREAM;
            STREAM:  if (accept && word_tc)     state_nxt = LOAD;
            LOAD: begin
               if (row_tc)                      state_nxt = IDLE;
               else if (ROW_GAP > 0)            state_nxt = GAP;
               else                             state_nxt = STREAM;
            end
            GAP:     if (gap_cnt == '0)         state_nxt = STREAM;
            default:                            state_nxt = IDLE;
         endcase
      end
   end

   // Outputs decoded from state; row_load/done are withheld on abort.
   always_comb begin
      ms.in_ready = (state == STREAM);
      ms.row_load = (state == LOAD) && !abort;
      done        = (state == LOAD) && !abort && row_tc;
      busy        = (state != IDLE);
   end

   // Word index is only ever zero outside STREAM, so a new row always starts at word 0.
   assign word_clr = abort || (state != STREAM);

   mask_row_counter #(
      .W   (WCNT_W),
      .MAX (WORDS_PER_ROW - 1)
   ) u_word_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (word_clr),
      .en    (accept),
      .count (word_cnt),
      .tc    (word_tc)
   );

   // Only the terminal flag of the word counter drives control.
   logic unused_word_bits;
   assign unused_word_bits = ^word_cnt;

   // Row address advances on entry to the next row's STREAM, returns to 0 at frame end.
   assign row_clr = abort || (state == IDLE) || ((state == LOAD) && row_tc);
   assign row_en  = ((state == LOAD) || (state == GAP)) && (state_nxt == STREAM);

   mask_row_counter #(
      .W   (ROWADD_W),
      .MAX (NUM_ROW - 1)
   ) u_row_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (row_clr),
      .en    (row_en),
      .count (row_cnt),
      .tc    (row_tc)
   );

   assign ms.rowadd = row_cnt;

   // Inter-row gap countdown, loaded in LOAD so GAP lasts exactly ROW_GAP cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         gap_cnt <= '0;
      else if (abort)
         gap_cnt <= '0;
      else if (state == LOAD)
         gap_cnt <= GAP_W'(GAP_INIT);
      else if ((state == GAP) && (gap_cnt != '0))
         gap_cnt <= gap_cnt - 1'b1;
   end

   // Capture accepted word; valid follows the accept by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ms.mstream       <= '0;
         ms.mstream_valid <= 1'b0;
      end else begin
         ms.mstream_valid <= accept;
         if (accept)
            ms.mstream <= ms.in_data;
      end
   end

   // Sticky starvation flag, cleared only by a fresh frame start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         underrun <= 1'b0;
      else if (start_acc)
         underrun <= 1'b0;
      else if (ms.in_ready && !ms.in_valid)
         underrun <= 1'b1;
   end

endmodule

// File: tb/tb_mask_stream_tx.sv
// Directed bench: two instances (ROW_GAP=2 and ROW_GAP=0), NUM_ROW=4, WORDS_PER_ROW=3.
module tb_mask_stream_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0;
   logic busy0, done0, und0, busy1, done1, und1;

   mask_stream_tx_if ms0 ();
   mask_stream_tx_if ms1 ();

   mask_stream_tx #(.NUM_ROW(4), .WORDS_PER_ROW(3), .ROW_GAP(2)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .abort(abort0), .ms(ms0),
      .busy(busy0), .done(done0), .underrun(und0));

   mask_stream_tx #(.NUM_ROW(4), .WORDS_PER_ROW(3), .ROW_GAP(0)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .ms(ms1),
      .busy(busy1), .done(done1), .underrun(und1));

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // upstream source for dut0: counts from 1, optional 5-cycle drop after a given word
   logic [15:0] src_d = 16'd1;
   int          stall_cnt = 0;
   logic        src_rst = 1'b0, src_en = 1'b0;
   logic [15:0] stall_after = 16'd0;
   assign ms0.in_valid = src_en && (stall_cnt == 0);
   assign ms0.in_data  = src_d;
   always @(posedge clk) begin
      if (src_rst) begin
         src_d     <= 16'd1;
         stall_cnt <= 0;
      end else begin
         if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
         if (ms0.in_valid && ms0.in_ready) begin
            src_d <= src_d + 16'd1;
            if (src_d == stall_after) stall_cnt <= 5;
         end
      end
   end

   logic [15:0] src1 = 16'd1;
   assign ms1.in_valid = 1'b1;
   assign ms1.in_data  = src1;
   always @(posedge clk) if (ms1.in_valid && ms1.in_ready) src1 <= src1 + 16'd1;

   // event recorders, sampled mid-cycle
   logic [15:0] dq[$];
   int rlq[$], rrq[$], bq[$];
   int done_cnt = 0, done_row = -1;
   logic bprev = 1'b0;
   logic [15:0] d1q[$];
   int rl1q[$], b1q[$];
   int done1_cnt = 0;
   logic b1prev = 1'b0;
   always @(negedge clk) begin
      if (ms0.mstream_valid) dq.push_back(ms0.mstream);
      if (ms0.row_load) begin
         rlq.push_back(cyc);
         rrq.push_back(int'(ms0.rowadd));
      end
      if (done0) begin
         done_cnt++;
         done_row = ms0.row_load ? int'(ms0.rowadd) : -1;
      end
      if (busy0 && !bprev) bq.push_back(cyc);
      bprev = busy0;
      if (ms1.mstream_valid) d1q.push_back(ms1.mstream);
      if (ms1.row_load) rl1q.push_back(cyc);
      if (done1) done1_cnt++;
      if (busy1 && !b1prev) b1q.push_back(cyc);
      b1prev = busy1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start0;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
   endtask

   task automatic wait_idle0(input string tag);
      int n = 0;
      while (busy0 && n < 300) begin
         tick();
         n++;
      end
      chk(tag, busy0, 1'b0);
   endtask

   task automatic wait_row0(input int r, input string tag);
      int n = 0;
      while (!(int'(ms0.rowadd) == r && ms0.in_ready) && n < 200) begin
         tick();
         n++;
      end
      chk(tag, (int'(ms0.rowadd) == r) && ms0.in_ready, 1'b1);
   endtask

   task automatic src_restart(input logic [15:0] sa);
      src_rst = 1'b1;
      stall_after = sa;
      tick();
      src_rst = 1'b0;
      src_en = 1'b1;
   endtask

   // one full frame on dut0, then row/data/done checks; gap1 is the expected row0->row1 spacing
   task automatic frame0(input string tag, input int gap1, input logic und_exp);
      int bI, rI, dI, d0;
      bI = bq.size(); rI = rlq.size(); dI = dq.size(); d0 = done_cnt;
      pulse_start0();
      chk({tag, "_busy"}, busy0, 1'b1);
      chk({tag, "_rdy"}, ms0.in_ready, 1'b1);
      wait_idle0({tag, "_end"});
      chk({tag, "_nrl"}, rlq.size() - rI, 4);
      chk({tag, "_ndat"}, dq.size() - dI, 12);
      if (rlq.size() - rI == 4 && bq.size() > bI) begin
         chk({tag, "_lat"}, rlq[rI] - bq[bI], 3);
         chk({tag, "_sp1"}, rlq[rI+1] - rlq[rI], gap1);
         chk({tag, "_sp2"}, rlq[rI+2] - rlq[rI+1], 6);
         chk({tag, "_sp3"}, rlq[rI+3] - rlq[rI+2], 6);
         for (int i = 0; i < 4; i++) chk({tag, "_row"}, rrq[rI+i], i);
      end
      if (dq.size() - dI == 12)
         for (int i = 0; i < 12; i++) chk({tag, "_dat"}, dq[dI+i], i + 1);
      chk({tag, "_done"}, done_cnt - d0, 1);
      chk({tag, "_donerow"}, done_row, 3);
      chk({tag, "_und"}, und0, und_exp);
      chk({tag, "_rowadd0"}, ms0.rowadd, 0);
   endtask

   initial begin
      int nrl, nd, rI, d0, b1I, r1I, d1I;
      // reset state
      repeat (3) tick();
      chk("rst_busy", busy0, 1'b0);
      chk("rst_rdy", ms0.in_ready, 1'b0);
      chk("rst_rowadd", ms0.rowadd, 0);
      chk("rst_mstream", ms0.mstream, 0);
      chk("rst_mvalid", ms0.mstream_valid, 1'b0);
      chk("rst_rowload", ms0.row_load, 1'b0);
      chk("rst_done", done0, 1'b0);
      chk("rst_und", und0, 1'b0);
      rst = 1'b0;
      tick();

      // clean frame, then frame with 5-cycle stall in row 1
      src_restart(16'd0);
      frame0("f1", 6, 1'b0);
      src_restart(16'd4);
      frame0("f2", 11, 1'b1);
      stall_after = 16'd0;

      // abort during row 2 word 1
      pulse_start0();
      chk("ab_undclr", und0, 1'b0);
      wait_row0(2, "ab_reach");
      tick();
      abort0 = 1'b1;
      tick();
      abort0 = 1'b0;
      chk("ab_busy", busy0, 1'b0);
      chk("ab_rowadd", ms0.rowadd, 0);
      chk("ab_rdy", ms0.in_ready, 1'b0);
      nrl = rlq.size(); nd = done_cnt;
      repeat (10) tick();
      chk("ab_norl", rlq.size() - nrl, 0);
      chk("ab_nodone", done_cnt - nd, 0);

      // restart from row 0, with a start pulse while busy
      rI = rlq.size(); d0 = done_cnt;
      pulse_start0();
      chk("rs_busy", busy0, 1'b1);
      chk("rs_rowadd", ms0.rowadd, 0);
      chk("rs_rdy", ms0.in_ready, 1'b1);
      repeat (5) tick();
      pulse_start0();
      wait_idle0("rs_end");
      chk("rs_nrl", rlq.size() - rI, 4);
      if (rlq.size() - rI == 4) begin
         chk("rs_row0", rrq[rI], 0);
         chk("rs_row3", rrq[rI+3], 3);
      end
      chk("rs_done", done_cnt - d0, 1);

      // start and abort together
      start0 = 1'b1; abort0 = 1'b1;
      tick();
      start0 = 1'b0; abort0 = 1'b0;
      chk("sa_busy", busy0, 1'b0);
      chk("sa_rdy", ms0.in_ready, 1'b0);
      tick();
      chk("sa_busy2", busy0, 1'b0);

      // async reset mid-STREAM in row 1 with underrun set
      src_restart(16'd2);
      pulse_start0();
      wait_row0(1, "ar_reach");
      chk("ar_pre_und", und0, 1'b1);
      chk("ar_pre_mnz", ms0.mstream != 16'd0, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_busy", busy0, 1'b0);
      chk("ar_rdy", ms0.in_ready, 1'b0);
      chk("ar_rowadd", ms0.rowadd, 0);
      chk("ar_mstream", ms0.mstream, 0);
      chk("ar_mvalid", ms0.mstream_valid, 1'b0);
      chk("ar_rowload", ms0.row_load, 1'b0);
      chk("ar_done", done0, 1'b0);
      chk("ar_und", und0, 1'b0);
      tick();
      rst = 1'b0;
      stall_after = 16'd0;
      tick();

      // ROW_GAP=0 instance: row period = WORDS_PER_ROW + 1
      b1I = b1q.size(); r1I = rl1q.size(); d1I = d1q.size();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      begin
         int n = 0;
         while (busy1 && n < 200) begin
            tick();
            n++;
         end
      end
      chk("g0_end", busy1, 1'b0);
      chk("g0_nrl", rl1q.size() - r1I, 4);
      if (rl1q.size() - r1I == 4 && b1q.size() > b1I) begin
         chk("g0_lat", rl1q[r1I] - b1q[b1I], 3);
         for (int i = 0; i < 3; i++) chk("g0_sp", rl1q[r1I+i+1] - rl1q[r1I+i], 4);
      end
      chk("g0_ndat", d1q.size() - d1I, 12);
      if (d1q.size() - d1I == 12) chk("g0_last", d1q[d1I+11], 12);
      chk("g0_done", done1_cnt, 1);
      chk("g0_und", und1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
